// File: rtl/mmio_responder.sv
// MMIO responder on the 8-bit data-memory bus: TX FIFO, RX capture, status/overflow, free-running timer.
// Define MMIO_IRQ_EN to add the MASK register at offset 0x4 and a registered interrupt output.
module mmio_responder #(
   parameter logic [7:0] BASE_ADDR  = 8'hF0,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       MemRead,
   input  logic       wren,
   input  logic [7:0] address,
   input  logic [7:0] data,
   output logic [7:0] q,
   output logic       hit,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_in,
   input  logic       rx_strobe,
   output logic       irq
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h1;
   localparam logic [3:0] OFF_RXDATA = 4'h2;
   localparam logic [3:0] OFF_TIMER  = 4'h3;
   localparam logic [3:0] OFF_MASK   = 4'h4;

   logic [7:0]     r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0] r_count;
   logic           r_overflow;
   logic           r_rx_valid;
   logic [7:0]     r_rx_reg;
   logic [7:0]     r_timer;
   logic [7:0]     r_q;
   logic           r_hit;

   logic           w_win;
   logic [3:0]     w_off;
   logic           w_full;
   logic           w_empty;
   logic           w_push_req;
   logic           w_push;
   logic           w_pop;
   logic           w_ovf_set;
   logic           w_rd_rx;
   logic [7:0]     w_status;
   logic [7:0]     w_rd_val;

   assign w_win      = (address[7:4] == BASE_ADDR[7:4]);
   assign w_off      = address[3:0];
   assign w_full     = (r_count == DEPTH_C);
   assign w_empty    = (r_count == '0);
   assign w_pop      = tx_valid & tx_ready;
   assign w_push_req = wren & w_win & (w_off == OFF_TXDATA);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_ovf_set  = w_push_req & w_full & ~w_pop;
   assign w_rd_rx    = MemRead & w_win & (w_off == OFF_RXDATA);
   assign w_status   = {4'b0000, r_overflow, w_full, w_empty, r_rx_valid};

   assign tx_valid = ~w_empty;
   assign tx_data  = r_mem[r_rd_ptr];
   assign q        = r_q;
   assign hit      = r_hit;

`ifdef MMIO_IRQ_EN
   logic [2:0] r_mask;
   logic       r_irq;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mask <= 3'b000;
         r_irq  <= 1'b0;
      end else begin
         if (wren && w_win && (w_off == OFF_MASK))
            r_mask <= data[2:0];
         r_irq <= |(r_mask & {r_overflow, w_empty, r_rx_valid});
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rd_val = 8'h00;
      case (w_off)
         OFF_STATUS: w_rd_val = w_status;
         OFF_RXDATA: w_rd_val = r_rx_reg;
         OFF_TIMER:  w_rd_val = r_timer;
`ifdef MMIO_IRQ_EN
         OFF_MASK:   w_rd_val = {5'b00000, r_mask};
`endif
         default:    w_rd_val = 8'h00;
      endcase
   end

   // Read data is taken from pre-edge state, so a same-cycle write is not visible.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q   <= 8'h00;
         r_hit <= 1'b0;
      end else if (MemRead && w_win) begin
         r_q   <= w_rd_val;
         r_hit <= 1'b1;
      end else begin
         r_q   <= 8'h00;
         r_hit <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_reg   <= 8'h00;
         r_timer    <= 8'h00;
      end else begin
         if (w_ovf_set)
            r_overflow <= 1'b1;
         else if (wren && w_win && (w_off == OFF_STATUS))
            r_overflow <= 1'b0;

         // A new strobe keeps rx_valid set even when RXDATA is read on the same edge.
         if (rx_strobe) begin
            r_rx_reg   <= rx_in;
            r_rx_valid <= 1'b1;
         end else if (w_rd_rx) begin
            r_rx_valid <= 1'b0;
         end

         if (wren && w_win && (w_off == OFF_TIMER))
            r_timer <= data;
         else
            r_timer <= r_timer + 8'd1;
      end
   end

endmodule
